// File: rtl/dmem_store_buffer_ctrl.sv
// Data-memory controller: posts core stores into an in-order buffer that drains
// to a slow req/ack word RAM; loads stall until the buffer is empty and the read returns.
module dmem_store_buffer_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic                       memwrite,
  input  logic                       memread,
  output logic [31:0]                rdata,
  output logic                       stall,
  output logic                       ram_req,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [31:0]                ram_wdata,
  input  logic                       ram_ack,
  input  logic [31:0]                ram_rdata,
  output logic [$clog2(DEPTH):0]     sb_count
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] sb_addr [DEPTH];
  logic [31:0]       sb_data [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW:0]       count;
  logic              rd_done;
  logic              full, push, pop;
  logic              issue_wr, issue_rd, read_done;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign full     = (count == (PW+1)'(DEPTH));
  assign push     = memwrite & ~full;
  assign pop      = (state == WR_WAIT) & ram_ack;
  assign stall    = (memwrite & full) | (memread & ~memwrite & ~rd_done);
  assign sb_count = count;

  // rd_done gates a new read so the cycle that returns data does not relaunch it.
  always_comb begin
    next_state = state;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    read_done  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          issue_wr   = 1'b1;
          next_state = WR_WAIT;
        end else if (memread & ~memwrite & ~rd_done) begin
          issue_rd   = 1'b1;
          next_state = RD_WAIT;
        end
      end
      WR_WAIT: if (ram_ack) next_state = IDLE;
      RD_WAIT: begin
        if (ram_ack) begin
          read_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata     <= '0;
      rd_done   <= 1'b0;
    end else begin
      state   <= next_state;
      rd_done <= read_done;
      if (issue_wr) begin
        ram_req   <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= sb_addr[head];
        ram_wdata <= sb_data[head];
      end else if (issue_rd) begin
        ram_req  <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= addr[ADDR_W+1:2];
      end else if (state != IDLE && ram_ack) begin
        ram_req <= 1'b0;
      end
      if (read_done) rdata <= ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= addr[ADDR_W+1:2];
      sb_data[tail] <= wdata;
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer_ctrl.sv
// Bench for dmem_store_buffer_ctrl: vector table, directed corner sequences and
// randomized core traffic checked against a memory/queue reference model.
module tb_dmem_store_buffer_ctrl;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       addr, wdata;
  logic              memwrite, memread;
  logic [31:0]       rdata;
  logic              stall, ram_req, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_ack;
  logic [31:0]       ram_rdata;
  logic [2:0]        sb_count;

  dmem_store_buffer_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .memwrite(memwrite), .memread(memread), .rdata(rdata), .stall(stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slow RAM: acks 'lat' cycles after req rises while ack_en is set.
  logic [31:0] mem [0:1023] = '{default: '0};
  bit  ack_en = 1'b1;
  int  lat = 0;
  int  wait_cnt = 0;
  int  wr_cnt = 0;
  int  rd_cnt = 0;

  assign ram_ack   = ram_req && ack_en && (wait_cnt >= lat);
  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (!ram_req || ram_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (ram_req && ram_ack && ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_req && ram_ack && !ram_we) rd_cnt <= rd_cnt + 1;
  end

  // Reference: accepted stores queue up in order; RAM writes must retire them FIFO.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } st_t;
  st_t         exp_q[$];
  logic [31:0] ref_mem [0:1023] = '{default: '0};

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      ref_mem = mem;
    end else begin
      chk("sb_count", 32'(sb_count), exp_q.size());
      if (ram_req && !ram_we) chk("read_behind_store", exp_q.size(), 0);
      if (ram_req && ram_ack && ram_we) begin
        chk("write_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("wr_addr", 32'(ram_addr), 32'(exp_q[0].a));
          chk("wr_data", ram_wdata, exp_q[0].d);
          void'(exp_q.pop_front());
        end
      end
      if (memwrite && !stall) begin
        exp_q.push_back('{addr[ADDR_W+1:2], wdata});
        ref_mem[addr[ADDR_W+1:2]] = wdata;
      end
    end
  end

  task automatic set_in(logic mw, logic mr, logic [31:0] a, logic [31:0] d);
    memwrite = mw; memread = mr; addr = a; wdata = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_store(logic [31:0] a, logic [31:0] d, logic also_read);
    bit ok = 1'b0;
    set_in(1'b1, also_read, a, d);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin ok = 1'b1; break; end
      step();
    end
    chk("store_accept_timeout", 32'(ok), 1);
    step();
    set_in(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_load(logic [31:0] a, logic [31:0] exp);
    bit ok = 1'b0;
    set_in(1'b0, 1'b1, a, '0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!stall) begin ok = 1'b1; break; end
      step();
    end
    chk("load_timeout", 32'(ok), 1);
    chk("load_data", rdata, exp);
    step();
    set_in(1'b0, 1'b0, '0, '0);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb_count == 0 && !ram_req) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", 32'(ok), 1);
    step();
  endtask

  typedef struct {
    logic        mw, mr;
    logic [31:0] a, d;
    logic        exp_stall;
    logic [2:0]  exp_cnt;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int w0, r0;
    logic [31:0] ra;
    tbl[0] = '{1'b1, 1'b0, 32'h400, 32'hA1, 1'b0, 3'd1};
    tbl[1] = '{1'b1, 1'b0, 32'h404, 32'hA2, 1'b0, 3'd2};
    tbl[2] = '{1'b1, 1'b0, 32'h408, 32'hA3, 1'b0, 3'd3};
    tbl[3] = '{1'b1, 1'b0, 32'h40C, 32'hA4, 1'b0, 3'd4};
    tbl[4] = '{1'b1, 1'b0, 32'h410, 32'hA5, 1'b1, 3'd4};
    tbl[5] = '{1'b0, 1'b1, 32'h400, 32'h0,  1'b1, 3'd4};
    tbl[6] = '{1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 3'd4};

    reset = 1'b1;
    set_in(1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_req", 32'(ram_req), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_sb_count", 32'(sb_count), 0);
    chk("rst_stall", 32'(stall), 0);
    step();
    reset = 1'b0;

    // Reset in the middle of a write with three stores pending.
    ack_en = 1'b0;
    do_store(32'h300, 32'h1, 1'b0);
    do_store(32'h304, 32'h2, 1'b0);
    do_store(32'h308, 32'h3, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 32'(sb_count), 3);
    chk("pre_rst_req", 32'(ram_req), 1);
    chk("pre_rst_we", 32'(ram_we), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(ram_req), 0);
    chk("async_rst_count", 32'(sb_count), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ack_en = 1'b1;
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    chk("post_rst_no_write", wr_cnt, w0);
    chk("post_rst_idle_req", 32'(ram_req), 0);
    step();

    // Fill the buffer with the RAM frozen, then let the 5th store in.
    ack_en = 1'b0;
    foreach (tbl[i]) begin
      set_in(tbl[i].mw, tbl[i].mr, tbl[i].a, tbl[i].d);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
      step();
      chk($sformatf("vec%0d_count", i), 32'(sb_count), 32'(tbl[i].exp_cnt));
    end
    set_in(1'b1, 1'b0, 32'h410, 32'hA5);
    ack_en = 1'b1;
    @(negedge clk);
    chk("full_pop_stall", 32'(stall), 1);
    step();
    chk("after_pop_count", 32'(sb_count), 3);
    @(negedge clk);
    chk("fifth_accept_stall", 32'(stall), 0);
    step();
    chk("fifth_push_count", 32'(sb_count), 4);
    set_in(1'b0, 1'b0, '0, '0);
    wait_drain();
    do_load(32'h40C, 32'hA4);
    do_load(32'h410, 32'hA5);

    // Single load, immediate ack.
    lat = 0;
    do_store(32'h10, 32'hDEADBEEF, 1'b0);
    wait_drain();
    set_in(1'b0, 1'b1, 32'h10, '0);
    @(negedge clk);
    chk("ld_stall_c1", 32'(stall), 1);
    step();
    @(negedge clk);
    chk("ld_stall_c2", 32'(stall), 1);
    chk("ld_req", 32'(ram_req), 1);
    chk("ld_addr", 32'(ram_addr), 4);
    chk("ld_we", 32'(ram_we), 0);
    step();
    @(negedge clk);
    chk("ld_stall_c3", 32'(stall), 0);
    chk("ld_rdata", rdata, 32'hDEADBEEF);
    step();
    set_in(1'b0, 1'b0, '0, '0);

    // Store then load of the same word, RAM latency 2.
    lat = 2;
    set_in(1'b1, 1'b0, 32'h20, 32'h11);
    @(negedge clk);
    chk("st_nostall", 32'(stall), 0);
    step();
    do_load(32'h20, 32'h11);

    // Push and pop in the same cycle keep occupancy and order.
    lat = 0;
    wait_drain();
    set_in(1'b1, 1'b0, 32'h0, 32'h1); step();
    set_in(1'b1, 1'b0, 32'h4, 32'h2); step();
    set_in(1'b1, 1'b0, 32'h8, 32'h3);
    @(negedge clk);
    chk("pp_stall", 32'(stall), 0);
    chk("pp_pop", 32'(ram_req && ram_ack), 1);
    step();
    chk("pp_count", 32'(sb_count), 2);
    set_in(1'b0, 1'b0, '0, '0);
    wait_drain();
    chk("pp_mem0", mem[0], 32'h1);
    chk("pp_mem1", mem[1], 32'h2);
    chk("pp_mem2", mem[2], 32'h3);

    // Simultaneous memwrite/memread acts as a store only.
    r0 = rd_cnt;
    set_in(1'b1, 1'b1, 32'h40, 32'h55);
    @(negedge clk);
    chk("both_stall", 32'(stall), 0);
    step();
    set_in(1'b0, 1'b0, '0, '0);
    wait_drain();
    chk("both_no_read", rd_cnt, r0);
    do_load(32'h40, 32'h55);

    // Random core traffic against the reference memory.
    for (int n = 0; n < 300; n++) begin
      int op;
      lat = $urandom_range(0, 3);
      op  = $urandom_range(0, 9);
      ra  = 32'h200 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if (op < 5)       do_store(ra, $urandom, 1'b0);
      else if (op < 8)  do_load(ra, ref_mem[ra[ADDR_W+1:2]]);
      else if (op == 8) do_store(ra, $urandom, 1'b1);
      else              step();
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
